// File: rtl/ssd_scan_decoder.sv
`default_nettype none
// ===========================================================================
// ssd_scan_decoder : recovers per-digit glyphs from a multiplexed, active-low 4-digit 7-seg scan.
// Optional: define SSD_DP_CAPTURE_EN to also track and capture decimal points.   Rev 1.0
// ===========================================================================
module ssd_scan_decoder #(
   parameter int STABLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 262143
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] an_in,
   input  logic [6:0] seg_in,
   input  logic       dp_in,
   output logic [6:0] seg0_out,
   output logic [6:0] seg1_out,
   output logic [6:0] seg2_out,
   output logic [6:0] seg3_out,
   output logic [3:0] hex0,
   output logic [3:0] hex1,
   output logic [3:0] hex2,
   output logic [3:0] hex3,
   output logic [3:0] hex_valid,
   output logic [3:0] dp_out,
   output logic       frame_done,
   output logic       scan_err,
   output logic       stale
);
   localparam int SW = $clog2(STABLE_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);
`ifdef SSD_DP_CAPTURE_EN
   localparam int IW = 12;
`else
   localparam int IW = 11;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] in_q, in_d, prev_q, prev_d;
   logic [SW-1:0] stab_q, stab_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [3:0]    mask_q, mask_d;
   logic [6:0]    seg_q [4];
   logic [6:0]    seg_d [4];
   logic [3:0]    hex_q [4];
   logic [3:0]    hex_d [4];
   logic [3:0]    valid_q, valid_d;
   logic          frame_q, frame_d, err_q, err_d;
   logic [3:0]    an;
   logic [6:0]    seg;
   logic          changed, blank, legal, capture;
   logic [1:0]    idx;
   logic [4:0]    dec;
   logic [3:0]    mask_n;
`ifdef SSD_DP_CAPTURE_EN
   logic [3:0]    dpc_q, dpc_d;
`else
   logic          unused_dp;
   assign unused_dp = dp_in;
`endif

   // {valid, nibble} for an active-low glyph
   function automatic logic [4:0] decode_glyph(input logic [6:0] p);
      case (p)
         7'h01: decode_glyph = 5'h10;  7'h4F: decode_glyph = 5'h11;
         7'h12: decode_glyph = 5'h12;  7'h06: decode_glyph = 5'h13;
         7'h4C: decode_glyph = 5'h14;  7'h24: decode_glyph = 5'h15;
         7'h20: decode_glyph = 5'h16;  7'h0F: decode_glyph = 5'h17;
         7'h00: decode_glyph = 5'h18;  7'h04: decode_glyph = 5'h19;
         7'h08: decode_glyph = 5'h1A;  7'h60: decode_glyph = 5'h1B;
         7'h31: decode_glyph = 5'h1C;  7'h42: decode_glyph = 5'h1D;
         7'h30: decode_glyph = 5'h1E;  7'h38: decode_glyph = 5'h1F;
         default: decode_glyph = 5'h00;
      endcase
   endfunction

   assign an  = in_q[IW-1 -: 4];
   assign seg = in_q[IW-5 -: 7];

   always_comb begin
`ifdef SSD_DP_CAPTURE_EN
      in_d  = {an_in, seg_in, dp_in};
      dpc_d = dpc_q;
`else
      in_d  = {an_in, seg_in};
`endif
      prev_d  = in_q;
      changed = (in_q != prev_q);
      blank   = (an == 4'hF);
      legal   = 1'b1;
      idx     = 2'd0;
      case (an)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: legal = 1'b0;
      endcase

      stab_d = changed ? SW'(1) : ((stab_q == STAB_MAX) ? stab_q : stab_q + SW'(1));

      state_d = state_q;
      case (state_q)
         IDLE:    if (!blank) state_d = SETTLE;
         SETTLE:  if (stab_d == STAB_MAX) state_d = HOLD;
         HOLD:    if (changed) state_d = SETTLE;
         default: state_d = IDLE;
      endcase
      if (blank) state_d = IDLE;

      // One decision per stable window, taken on the SETTLE->HOLD edge
      capture = (state_q == SETTLE) && (state_d == HOLD);
      dec     = decode_glyph(seg);
      mask_n  = mask_q | (4'b0001 << idx);

      seg_d   = seg_q;
      hex_d   = hex_q;
      valid_d = valid_q;
      mask_d  = mask_q;
      frame_d = 1'b0;
      err_d   = 1'b0;
      if (capture) begin
         if (legal) begin
            seg_d[idx]   = seg;
            hex_d[idx]   = dec[3:0];
            valid_d[idx] = dec[4];
`ifdef SSD_DP_CAPTURE_EN
            dpc_d[idx]   = in_q[0];
`endif
            if (mask_n == 4'hF) begin
               frame_d = 1'b1;
               mask_d  = 4'h0;
            end else begin
               mask_d  = mask_n;
            end
         end else begin
            err_d = 1'b1;
         end
      end

      tmo_d = (capture && legal) ? '0 : ((tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         in_q    <= '1;
         prev_q  <= '1;
         stab_q  <= '0;
         tmo_q   <= '0;
         mask_q  <= 4'h0;
         for (int k = 0; k < 4; k++) begin
            seg_q[k] <= 7'h7F;
            hex_q[k] <= 4'h0;
         end
         valid_q <= 4'h0;
         frame_q <= 1'b0;
         err_q   <= 1'b0;
`ifdef SSD_DP_CAPTURE_EN
         dpc_q   <= 4'hF;
`endif
      end else begin
         state_q <= state_d;
         in_q    <= in_d;
         prev_q  <= prev_d;
         stab_q  <= stab_d;
         tmo_q   <= tmo_d;
         mask_q  <= mask_d;
         seg_q   <= seg_d;
         hex_q   <= hex_d;
         valid_q <= valid_d;
         frame_q <= frame_d;
         err_q   <= err_d;
`ifdef SSD_DP_CAPTURE_EN
         dpc_q   <= dpc_d;
`endif
      end
   end

   assign seg0_out   = seg_q[0];
   assign seg1_out   = seg_q[1];
   assign seg2_out   = seg_q[2];
   assign seg3_out   = seg_q[3];
   assign hex0       = hex_q[0];
   assign hex1       = hex_q[1];
   assign hex2       = hex_q[2];
   assign hex3       = hex_q[3];
   assign hex_valid  = valid_q;
   assign frame_done = frame_q;
   assign scan_err   = err_q;
   assign stale      = (tmo_q == TMO_MAX);
`ifdef SSD_DP_CAPTURE_EN
   assign dp_out     = dpc_q;
`else
   assign dp_out     = 4'hF;
`endif

endmodule
`default_nettype wire
